// File: rtl/dumbrv_pkg.sv
// Shared opcodes and state/operation types for the dumbrv SPI memory target.
package dumbrv_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_FREAD = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_IGNORE,
    ST_DUMMY
  } spi_tgt_state_t;

  typedef enum logic [1:0] {
    OP_READ,
    OP_WRITE,
    OP_FREAD
  } spi_tgt_op_t;

endpackage

// File: rtl/dumbrv_spi_sync.sv
// Multi-stage synchronizer with registered rise/fall detect; level_o is
// delayed one flop so it lines up with the edge strobes.
module dumbrv_spi_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
      level_q <= chain_q[SYNC_STAGES-1];
      rise_q  <= chain_q[SYNC_STAGES-1] & ~level_q;
      fall_q  <= ~chain_q[SYNC_STAGES-1] & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/dumbrv_spi_target.sv
// SPI mode-0 memory target: byte-serial READ/WRITE with 16-bit address.
// Optional FAST READ (0x0B + dummy byte) when DUMBRV_SPI_TGT_FASTREAD_EN is defined.
module dumbrv_spi_target
  import dumbrv_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              bad_cmd_o
);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  dumbrv_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst(rst), .d_i(spi_sck),
    .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  dumbrv_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .d_i(spi_cs),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  dumbrv_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(spi_mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused_sync = ^{sck_lvl, cs_lvl, mosi_rise, mosi_fall};

  spi_tgt_state_t    state_q, state_d;
  spi_tgt_op_t       op_q, op_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shin_q, shin_d;
  logic [7:0]        shout_q, shout_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              miso_q, miso_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              bad_cmd_q, bad_cmd_d;
  logic              rd_load_q;
  logic [7:0]        byte_in;
  logic [15:0]       addr_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      bitcnt_q    <= '0;
      shin_q      <= '0;
      shout_q     <= '0;
      addr_hi_q   <= '0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      bad_cmd_q   <= 1'b0;
      rd_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      bitcnt_q    <= bitcnt_d;
      shin_q      <= shin_d;
      shout_q     <= shout_d;
      addr_hi_q   <= addr_hi_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      bad_cmd_q   <= bad_cmd_d;
      rd_load_q   <= mem_en_q & ~mem_we_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    bitcnt_d    = bitcnt_q;
    shin_d      = shin_q;
    shout_d     = shout_q;
    addr_hi_d   = addr_hi_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    bad_cmd_d   = 1'b0;
    byte_in     = {shin_q[6:0], mosi_lvl};
    addr_full   = {addr_hi_q, byte_in};

    // Read data lands two cycles after the strobe; SCK falls are far enough apart not to collide.
    if (rd_load_q) shout_d = mem_rdata;

    if (cs_rise) begin
      state_d  = ST_IDLE;
      bitcnt_d = '0;
      miso_d   = 1'b0;
    end else if (cs_fall) begin
      state_d  = ST_CMD;
      bitcnt_d = '0;
      shout_d  = '0;
      miso_d   = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (sck_fall) begin
        if (state_q == ST_RD_DATA) begin
          miso_d  = shout_q[7];
          shout_d = {shout_q[6:0], 1'b0};
        end else begin
          miso_d = 1'b0;
        end
      end
      if (sck_rise) begin
        shin_d   = byte_in;
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          case (state_q)
            ST_CMD: begin
              case (byte_in)
                CMD_READ:  begin op_d = OP_READ;  state_d = ST_ADDR_HI; end
                CMD_WRITE: begin op_d = OP_WRITE; state_d = ST_ADDR_HI; end
`ifdef DUMBRV_SPI_TGT_FASTREAD_EN
                CMD_FREAD: begin op_d = OP_FREAD; state_d = ST_ADDR_HI; end
`endif
                default: begin
                  state_d   = ST_IGNORE;
                  bad_cmd_d = 1'b1;
                end
              endcase
            end
            ST_ADDR_HI: begin
              addr_hi_d = byte_in;
              state_d   = ST_ADDR_LO;
            end
            ST_ADDR_LO: begin
              addr_d = addr_full[ADDR_W-1:0];
              if (op_q == OP_WRITE) begin
                state_d = ST_WR_DATA;
`ifdef DUMBRV_SPI_TGT_FASTREAD_EN
              end else if (op_q == OP_FREAD) begin
                state_d = ST_DUMMY;
`else
`endif
              end else begin
                mem_en_d   = 1'b1;
                mem_addr_d = addr_full[ADDR_W-1:0];
                addr_d     = addr_full[ADDR_W-1:0] + 1'b1;
                state_d    = ST_RD_DATA;
              end
            end
            ST_DUMMY, ST_RD_DATA: begin
              // Prefetch of the next byte for the following SCK fall.
              mem_en_d   = 1'b1;
              mem_addr_d = addr_q;
              addr_d     = addr_q + 1'b1;
              state_d    = ST_RD_DATA;
            end
            ST_WR_DATA: begin
              mem_en_d    = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = addr_q;
              mem_wdata_d = byte_in;
              addr_d      = addr_q + 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign spi_miso  = miso_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign bad_cmd_o = bad_cmd_q;

endmodule
